log_event_collector: RTL and testbench
======================================

// Module: log_event_collector
// PURPOSE
// Synthesizable multi-channel successor to the unit-test logger. It collects
// severity-tagged events from N_CH sources, keeps per-severity saturating
// counters, and buffers filtered events with a timestamp in a FIFO.
// Sits beside the DUT in unit-test and on-chip debug builds; a bench or CPU
// drains the FIFO through a valid/ready stream.
// PARAMETERS
// N_CH         4    number of event source channels (>=1)
// CODE_W       16   width of per-event code
// DEPTH        8    FIFO entries (power of 2, >=2)
// TS_W         32   free-running timestamp width
// CNT_W        16   width of every counter
// DROP_ON_FULL 1    1: accept and drop stored-class events when full; 0: back-pressure
// PORTS
// clk        in   1              single clock, rising edge
// rst_n      in   1              asynchronous active-low reset
// clr        in   1              sync clear: counters, FIFO, timestamp, err_seen
// min_sev    in   2              store threshold (0 info,1 warn,2 error,3 fatal)
// evt_valid  in   N_CH           per-channel event valid
// evt_ready  out  N_CH           per-channel accept; handshake = valid & ready
// evt_sev    in   2*N_CH         severity, channel i at [2i+:2]
// evt_code   in   CODE_W*N_CH    code, channel i at [CODE_W*i+:CODE_W]
// rd_valid   out  1              FIFO head valid
// rd_ready   in   1              pop when rd_valid & rd_ready
// rd_ts      out  TS_W           head timestamp (ts value at acceptance cycle)
// rd_ch      out  CH_W           head channel, CH_W = max(1,$clog2(N_CH))
// rd_sev     out  2              head severity
// rd_code    out  CODE_W         head code
// sev_cnt    out  4*CNT_W        accepted count per severity, sev s at [CNT_W*s+:CNT_W]
// drop_cnt   out  CNT_W          stored-class events accepted but dropped (full)
// err_seen   out  1              sticky: any accepted event with sev>=2
// fifo_level out  $clog2(DEPTH+1) current entry count
// BEHAVIOUR
// - Reset (async, rst_n=0): all counters, ts, fifo_level, err_seen =0; rd_valid=0;
//   evt_ready=0; rd_* data =0; round-robin pointer =0. Mid-operation reset discards FIFO.
// - ts increments every cycle, wraps 2^TS_W-1 -> 0; clr forces ts to 0 next cycle.
// - Arbiter: at most one grant per cycle, round-robin over asserted evt_valid,
//   search starts at channel after last accepted one; pointer moves only on handshake.
// - evt_ready[i] = grant[i] & !clr & (sev<min_sev | !full | DROP_ON_FULL).
//   evt_ready is combinational on evt_valid/evt_sev; non-granted channels see 0.
// - On handshake: sev_cnt[sev]++ (saturate at 2^CNT_W-1); err_seen set if sev>=2.
//   sev<min_sev: counted only, never stored. sev>=min_sev and !full: written;
//   sev>=min_sev and full (DROP_ON_FULL=1): drop_cnt++ (saturating), not written.
// - Latency: event accepted in cycle t -> counters/err_seen/fifo_level updated and
//   rd_valid high at t+1 if FIFO was empty (no same-cycle bypass).
// - full = (fifo_level==DEPTH) from registered state; pop in same cycle does NOT
//   free space for a write that cycle. Simultaneous push+pop when 0<level<DEPTH:
//   level unchanged. Pointers wrap modulo DEPTH.
// - rd_* stable while rd_valid & !rd_ready; rd_* undefined-but-held when rd_valid=0.
// - clr (one cycle): next cycle all counters, drop_cnt, ts, fifo_level =0,
//   err_seen=0, rd_valid=0; no event accepted during the clr cycle; pop ignored.
// TESTING
// 1 reset: rst_n low mid-traffic -> all outputs 0 immediately, FIFO empty after release.
// 2 single ch0 sev=2 code=0x00AB at ts=10, min_sev=1 -> rd_valid next cycle,
//   rd_ts=10 rd_ch=0 rd_sev=2 rd_code=0x00AB; sev_cnt[2]=1; err_seen=1.
// 3 all 4 channels valid every cycle, rd_ready=1 -> grants ch0,1,2,3,0..; each
//   channel accepted once per 4 cycles; sev_cnt totals = accepted events.
// 4 DEPTH=8, rd_ready=0, 10 events sev=3: DROP_ON_FULL=1 -> level=8, drop_cnt=2;
//   DROP_ON_FULL=0 -> evt_ready low after 8th, stall until first pop.
// 5 min_sev=2, events sev=0,1 -> counted (sev_cnt[0]=1,[1]=1), FIFO stays empty,
//   accepted even when FIFO full; clr then -> all counts 0, err_seen 0.
// 6 CNT_W=4: 20 info events -> sev_cnt[0] saturates at 15; TS_W=4 ts wraps 15->0.

Source files
------------

// File: rtl/log_event_collector.sv
// Multi-channel event collector: round-robin intake, per-severity saturating
// counters, and a timestamped FIFO drained over a valid/ready stream.
module log_event_collector #(
  parameter int N_CH         = 4,
  parameter int CODE_W       = 16,
  parameter int DEPTH        = 8,
  parameter int TS_W         = 32,
  parameter int CNT_W        = 16,
  parameter int DROP_ON_FULL = 1,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [1:0]             min_sev,
  input  logic [N_CH-1:0]        evt_valid,
  output logic [N_CH-1:0]        evt_ready,
  input  logic [2*N_CH-1:0]      evt_sev,
  input  logic [CODE_W*N_CH-1:0] evt_code,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TS_W-1:0]        rd_ts,
  output logic [CH_W-1:0]        rd_ch,
  output logic [1:0]             rd_sev,
  output logic [CODE_W-1:0]      rd_code,
  output logic [4*CNT_W-1:0]     sev_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   err_seen,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CH_W-1:0]   ch;
    logic [1:0]        sev;
    logic [CODE_W-1:0] code;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [CH_W-1:0]   rr_ptr;
  logic [TS_W-1:0]   ts;
  logic [CNT_W-1:0]  cnt [4];

  logic              full, any_valid, stored_class, accept_ok;
  logic              hs, push, drop, pop;
  logic [CH_W-1:0]   gnt_ch;
  logic [1:0]        gnt_sev;
  logic [CODE_W-1:0] gnt_code;

  // Channel index base+k, wrapped modulo N_CH (N_CH need not be a power of 2).
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CH) s -= N_CH;
    return CH_W'(s);
  endfunction

  // Round-robin search starting at rr_ptr; first asserted valid wins.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    gnt_ch    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!any_valid && evt_valid[rr_idx(rr_ptr, k)]) begin
        any_valid = 1'b1;
        gnt_ch    = rr_idx(rr_ptr, k);
      end
    end
  end

  assign gnt_sev      = evt_sev[2*gnt_ch +: 2];
  assign gnt_code     = evt_code[CODE_W*gnt_ch +: CODE_W];
  assign full         = (level == LVL_W'(DEPTH));
  assign stored_class = (gnt_sev >= min_sev);
  assign accept_ok    = rst_n & !clr & (!stored_class | !full | (DROP_ON_FULL != 0));
  assign evt_ready    = (any_valid && accept_ok) ? (N_CH'(1) << gnt_ch) : '0;

  assign hs   = any_valid & accept_ok;
  assign push = hs & stored_class & !full;
  assign drop = hs & stored_class & full;
  // Pop only looks at registered occupancy; it never frees space for this cycle's push.
  assign pop  = (level != '0) & rd_ready & !clr;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
      err_seen <= 1'b0;
      for (int s = 0; s < 4; s++) cnt[s] <= '0;
      // NOTE: the storage array is reset too, so the head data reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      ts       <= '0;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      err_seen <= 1'b0;
      for (int s = 0; s < 4; s++) cnt[s] <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (hs) begin
        rr_ptr <= rr_idx(gnt_ch, 1);
        if (cnt[gnt_sev] != '1) cnt[gnt_sev] <= cnt[gnt_sev] + 1'b1;
        if (gnt_sev[1]) err_seen <= 1'b1;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{ts: ts, ch: gnt_ch, sev: gnt_sev, code: gnt_code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign rd_valid   = (level != '0);
  assign rd_ts      = head.ts;
  assign rd_ch      = head.ch;
  assign rd_sev     = head.sev;
  assign rd_code    = head.code;
  assign fifo_level = level;
  assign sev_cnt    = {cnt[3], cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_log_event_collector.sv
// Bench for log_event_collector: two configurations (wide/drop, narrow/back-pressure)
// share stimulus; a transaction-level model predicts readies, counters and FIFO contents.
module tb_log_event_collector;

  localparam int N_CH   = 4;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst_n, clr, rd_ready;
  logic [1:0]  min_sev;
  logic [3:0]  evt_valid;
  logic [7:0]  evt_sev;
  logic [63:0] evt_code;

  logic [3:0]  rdy_a, rdy_b, lvl_a, lvl_b, ts_b, drop_b;
  logic        rv_a, rv_b, err_a, err_b;
  logic [31:0] ts_a;
  logic [1:0]  ch_a, ch_b, sv_a, sv_b;
  logic [15:0] code_a, code_b, drop_a, cnt_b;
  logic [63:0] cnt_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  log_event_collector #(.N_CH(4), .CODE_W(16), .DEPTH(8), .TS_W(32), .CNT_W(16),
                        .DROP_ON_FULL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .min_sev(min_sev),
    .evt_valid(evt_valid), .evt_ready(rdy_a), .evt_sev(evt_sev), .evt_code(evt_code),
    .rd_valid(rv_a), .rd_ready(rd_ready), .rd_ts(ts_a), .rd_ch(ch_a), .rd_sev(sv_a),
    .rd_code(code_a), .sev_cnt(cnt_a), .drop_cnt(drop_a), .err_seen(err_a),
    .fifo_level(lvl_a));

  log_event_collector #(.N_CH(4), .CODE_W(16), .DEPTH(8), .TS_W(4), .CNT_W(4),
                        .DROP_ON_FULL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .min_sev(min_sev),
    .evt_valid(evt_valid), .evt_ready(rdy_b), .evt_sev(evt_sev), .evt_code(evt_code),
    .rd_valid(rv_b), .rd_ready(rd_ready), .rd_ts(ts_b), .rd_ch(ch_b), .rd_sev(sv_b),
    .rd_code(code_b), .sev_cnt(cnt_b), .drop_cnt(drop_b), .err_seen(err_b),
    .fifo_level(lvl_b));

  typedef struct {
    int unsigned ts;
    int          ch;
    int          sev;
    int          code;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int unsigned m_ts[2];
  int          m_cnt[2][4];
  int          m_drop[2], m_lvl[2], m_rr[2];
  bit          m_err[2];

  function automatic int cmax(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic int unsigned tsmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ts[d] = 0; m_drop[d] = 0; m_lvl[d] = 0; m_rr[d] = 0; m_err[d] = 1'b0;
      for (int s = 0; s < 4; s++) m_cnt[d][s] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  // Compare one configuration against the model, then advance the model across the edge.
  task automatic step(input int d, input logic [3:0] rdy, input logic [3:0] lvl,
                      input logic rv, input logic [63:0] cflat, input logic [15:0] dc,
                      input logic err);
    int   gc, c, s, cw;
    bit   stored, full, ok, pop;
    exp_t e;
    gc = -1;
    for (int k = 0; k < N_CH; k++) begin
      c = (m_rr[d] + k) % N_CH;
      if (gc < 0 && evt_valid[c]) gc = c;
    end
    s      = (gc >= 0) ? int'(evt_sev[2*gc +: 2]) : 0;
    stored = (gc >= 0) && (s >= int'(min_sev));
    full   = (m_lvl[d] == DEPTH);
    ok     = (gc >= 0) && !clr && (!stored || !full || d == 0);
    cw     = (d == 0) ? 16 : 4;

    check($sformatf("d%0d evt_ready", d), rdy, ok ? (64'd1 << gc) : 64'd0);
    check($sformatf("d%0d fifo_level", d), lvl, m_lvl[d]);
    check($sformatf("d%0d rd_valid", d), rv, m_lvl[d] > 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("d%0d sev_cnt[%0d]", d, k), (cflat >> (cw*k)) & cmax(d), m_cnt[d][k]);
    check($sformatf("d%0d drop_cnt", d), dc, m_drop[d]);
    check($sformatf("d%0d err_seen", d), err, m_err[d]);

    pop = (m_lvl[d] > 0) && rd_ready && !clr;
    if (clr) begin
      m_ts[d] = 0; m_drop[d] = 0; m_lvl[d] = 0; m_err[d] = 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      if (ok) begin
        m_rr[d] = (gc + 1) % N_CH;
        if (m_cnt[d][s] < cmax(d)) m_cnt[d][s]++;
        if (s >= 2) m_err[d] = 1'b1;
        if (stored && !full) begin
          e.ts = m_ts[d]; e.ch = gc; e.sev = s; e.code = int'(evt_code[16*gc +: 16]);
          if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
          m_lvl[d]++;
        end else if (stored && m_drop[d] < cmax(d)) begin
          m_drop[d]++;
        end
      end
      if (pop) m_lvl[d]--;
      m_ts[d] = (m_ts[d] + 1) & tsmask(d);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic [3:0] v, input logic [7:0] sv, input logic [63:0] cd,
                       input logic rr, input logic c, input logic [1:0] ms);
    evt_valid = v; evt_sev = sv; evt_code = cd; rd_ready = rr; clr = c; min_sev = ms;
    @(negedge clk);
    step(0, rdy_a, lvl_a, rv_a, cnt_a, drop_a, err_a);
    step(1, rdy_b, lvl_b, rv_b, {48'd0, cnt_b}, {12'd0, drop_b}, err_b);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_cmp(input int d, input logic [31:0] ts, input logic [1:0] ch,
                         input logic [1:0] sv, input logic [15:0] cd);
    exp_t e;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL d%0d pop: rd_valid=1 with no entry expected", d);
    end else begin
      e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("d%0d rd_ts", d), ts, e.ts);
      check($sformatf("d%0d rd_ch", d), ch, e.ch);
      check($sformatf("d%0d rd_sev", d), sv, e.sev);
      check($sformatf("d%0d rd_code", d), cd, e.code);
    end
  endtask

  // Monitor: compares the head whenever a pop handshake is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !clr && rd_ready) begin
        if (rv_a) pop_cmp(0, ts_a, ch_a, sv_a, code_a);
        if (rv_b) pop_cmp(1, {28'd0, ts_b}, ch_b, sv_b, code_b);
      end
    end
  end

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst rdy_a", rdy_a, 0);   check("rst rdy_b", rdy_b, 0);
    check("rst rv_a", rv_a, 0);     check("rst rv_b", rv_b, 0);
    check("rst lvl_a", lvl_a, 0);   check("rst lvl_b", lvl_b, 0);
    check("rst cnt_a", cnt_a, 0);   check("rst cnt_b", cnt_b, 0);
    check("rst drop_a", drop_a, 0); check("rst err_a", err_a, 0);
    check("rst ts_a", ts_a, 0);     check("rst code_a", code_a, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_code();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] all3;
    logic [1:0] ms;
    bit         rr_bias;
    all3 = 8'hFF;
    rst_n = 1'b0; clr = 1'b0; rd_ready = 1'b0; min_sev = 2'd0;
    evt_valid = '0; evt_sev = '0; evt_code = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single error event on ch0 at ts=10.
    repeat (10) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd1);
    cycle(4'h1, 8'h02, 64'h0000_0000_0000_00AB, 1'b1, 1'b0, 2'd1);
    repeat (3) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd1);

    // All channels requesting every cycle: strict rotation.
    repeat (16) cycle(4'hF, 8'($urandom), rand_code(), 1'b1, 1'b0, 2'd0);
    repeat (4) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd0);

    // Ten fatal events with no reader: drop vs back-pressure.
    repeat (10) cycle(4'h2, all3, rand_code(), 1'b0, 1'b0, 2'd1);
    // Low severities below threshold are still accepted while full.
    cycle(4'h4, 8'h00, rand_code(), 1'b0, 1'b0, 2'd2);
    cycle(4'h8, 8'h40, rand_code(), 1'b0, 1'b0, 2'd2);
    cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b1, 2'd2);
    repeat (2) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd2);

    // Back-pressured config drains and resumes.
    repeat (10) cycle(4'h2, all3, rand_code(), 1'b0, 1'b0, 2'd1);
    repeat (14) cycle(4'h2, all3, rand_code(), 1'b1, 1'b0, 2'd1);
    cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b1, 2'd0);

    // Twenty info events: narrow counter saturates, narrow timestamp wraps.
    repeat (20) cycle(4'h1, 8'h00, rand_code(), 1'b1, 1'b0, 2'd0);
    repeat (4) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd0);

    // Reset in the middle of traffic.
    repeat (6) cycle(4'hF, 8'($urandom), rand_code(), 1'b0, 1'b0, 2'd0);
    evt_valid = 4'hF;
    mid_reset();

    // Randomized traffic with reader phases, rare clears and threshold changes.
    ms = 2'd0;
    rr_bias = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        ms = 2'($urandom);
        rr_bias = $urandom_range(0, 1) != 0;
      end
      cycle(4'($urandom), 8'($urandom), rand_code(),
            rr_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
            $urandom_range(0, 99) == 0, ms);
    end
    repeat (20) cycle(4'h0, 8'h00, 64'd0, 1'b1, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
